// File: rtl/dmwb_pkg.sv
// Shared types and defaults for the data-memory coalescing write buffer.
// Entries store a 30-bit word address so any ADDR_W up to 29 fits one struct.
package dmwb_pkg;

    localparam int unsigned DMWB_DEPTH     = 4;
    localparam int unsigned DMWB_ADDR_W    = 14;
    localparam int unsigned DMWB_WADDR_MAX = 30;

    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_READ  = 2'd1,
        CYC_WRITE = 2'd2
    } cyc_t;

    typedef struct packed {
        logic                      valid;
        logic [DMWB_WADDR_MAX-1:0] addr;
        logic [31:0]               data;
        logic [3:0]                mask;
    } dmwb_entry_t;

    function automatic cyc_t classify(input logic cs, input logic oe, input logic [3:0] web);
        cyc_t c;
        c = CYC_IDLE;
        if (cs && web != 4'hF)
            c = CYC_WRITE;
        else if (cs && oe)
            c = CYC_READ;
        return c;
    endfunction

endpackage

// File: rtl/dmwb_merge.sv
// Per-byte lane merge: lanes with mask set come from 'over', the rest from 'base'.
module dmwb_merge (
    input  logic [31:0] base,
    input  logic [31:0] over,
    input  logic [3:0]  mask,
    output logic [31:0] result
);

    always_comb begin
        result = base;
        for (int unsigned b = 0; b < 4; b++) begin
            if (mask[b])
                result[b*8 +: 8] = over[b*8 +: 8];
        end
    end

endmodule

// File: rtl/dmem_write_buffer.sv
// Coalescing write buffer between the CPU data port and a single-port SRAM.
// Drains on idle cycles, or on a write that finds the buffer full; reads forward buffered bytes.
module dmem_write_buffer
    import dmwb_pkg::*;
#(
    parameter int unsigned DEPTH  = DMWB_DEPTH,
    parameter int unsigned ADDR_W = DMWB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_DM_CS,
    input  logic [3:0]        i_DM_WEB,
    input  logic              i_DM_OE,
    input  logic [31:0]       i_DM_addr,
    input  logic [31:0]       i_DM_DI,
    output logic [31:0]       o_DM_DO,
    output logic              o_SRAM_CS,
    output logic [3:0]        o_SRAM_WEB,
    output logic [ADDR_W-1:0] o_SRAM_A,
    output logic [31:0]       o_SRAM_DI,
    input  logic [31:0]       i_SRAM_DO,
    output logic              o_empty,
    output logic              o_full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    dmwb_entry_t               ent_q [DEPTH];
    logic [PTR_W-1:0]          head_q;
    logic [PTR_W-1:0]          tail_q;
    logic [PTR_W:0]            count_q;
    logic [3:0]                snap_mask_q;
    logic [31:0]               snap_data_q;
    logic                      rd_pend_q;
    logic [31:0]               dout_q;

    cyc_t                      cyc;
    logic [DMWB_WADDR_MAX-1:0] word;
    logic                      full;
    logic                      empty;
    logic                      drain;
    logic                      push;
    logic                      wr_hit;
    logic [PTR_W-1:0]          wr_hit_idx;
    logic [3:0]                rd_hit_mask;
    logic [31:0]               rd_hit_data;
    logic [3:0]                wr_mask;
    logic [31:0]               wr_base;
    logic [31:0]               wr_merged;
    logic [31:0]               rd_merged;
    logic                      unused_addr;

    assign unused_addr = ^{i_DM_addr[31:ADDR_W+2], i_DM_addr[1:0]};
    assign word        = DMWB_WADDR_MAX'(i_DM_addr[ADDR_W+1:2]);

    // Reset forces IDLE so the SRAM port is quiet while rst is low.
    assign cyc   = rst ? classify(i_DM_CS, i_DM_OE, i_DM_WEB) : CYC_IDLE;
    assign full  = (count_q == (PTR_W+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign drain = !empty && ((cyc == CYC_IDLE) || ((cyc == CYC_WRITE) && full));
    assign push  = (cyc == CYC_WRITE) && !wr_hit;

    assign wr_mask = ~i_DM_WEB;
    assign wr_base = ent_q[wr_hit_idx].data;

    // The draining head is excluded from write coalescing so bytes are never lost mid-drain.
    always_comb begin
        rd_hit_mask = '0;
        rd_hit_data = '0;
        wr_hit      = 1'b0;
        wr_hit_idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].addr == word) begin
                rd_hit_mask = ent_q[i].mask;
                rd_hit_data = ent_q[i].data;
                if (!(drain && PTR_W'(i) == head_q)) begin
                    wr_hit     = 1'b1;
                    wr_hit_idx = PTR_W'(i);
                end
            end
        end
    end

    dmwb_merge u_wr_merge (
        .base   (wr_base),
        .over   (i_DM_DI),
        .mask   (wr_mask),
        .result (wr_merged)
    );

    dmwb_merge u_rd_merge (
        .base   (i_SRAM_DO),
        .over   (snap_data_q),
        .mask   (snap_mask_q),
        .result (rd_merged)
    );

    always_comb begin
        o_SRAM_CS  = 1'b0;
        o_SRAM_WEB = '1;
        o_SRAM_A   = '0;
        o_SRAM_DI  = '0;
        if (cyc == CYC_READ) begin
            o_SRAM_CS = 1'b1;
            o_SRAM_A  = word[ADDR_W-1:0];
        end else if (drain) begin
            o_SRAM_CS  = 1'b1;
            o_SRAM_WEB = ~ent_q[head_q].mask;
            o_SRAM_A   = ent_q[head_q].addr[ADDR_W-1:0];
            o_SRAM_DI  = ent_q[head_q].data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                ent_q[i] <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            snap_mask_q <= '0;
            snap_data_q <= '0;
            rd_pend_q   <= 1'b0;
            dout_q      <= '0;
        end else begin
            if (drain) begin
                ent_q[head_q].valid <= 1'b0;
                head_q              <= head_q + PTR_W'(1);
            end
            if ((cyc == CYC_WRITE) && wr_hit) begin
                ent_q[wr_hit_idx].data <= wr_merged;
                ent_q[wr_hit_idx].mask <= ent_q[wr_hit_idx].mask | wr_mask;
            end
            // When full, tail equals the draining head; the push write below wins.
            if (push) begin
                ent_q[tail_q] <= '{valid: 1'b1, addr: word, data: i_DM_DI, mask: wr_mask};
                tail_q        <= tail_q + PTR_W'(1);
            end
            count_q <= count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, drain};

            rd_pend_q <= (cyc == CYC_READ);
            if (cyc == CYC_READ) begin
                snap_mask_q <= rd_hit_mask;
                snap_data_q <= rd_hit_data;
            end
            if (rd_pend_q)
                dout_q <= rd_merged;
        end
    end

    assign o_DM_DO = rd_pend_q ? rd_merged : dout_q;
    assign o_empty = empty;
    assign o_full  = full;

endmodule

// File: tb/tb_dmem_write_buffer.sv
// Scoreboard bench for dmem_write_buffer: expected SRAM writes and read data are queued
// by the stimulus and popped by a negedge monitor whenever the DUT presents them.
module tb_dmem_write_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_DM_CS = 1'b0;
    logic [3:0]  i_DM_WEB = 4'hF;
    logic        i_DM_OE = 1'b0;
    logic [31:0] i_DM_addr = '0;
    logic [31:0] i_DM_DI = '0;
    logic [31:0] o_DM_DO;
    logic        o_SRAM_CS;
    logic [3:0]  o_SRAM_WEB;
    logic [13:0] o_SRAM_A;
    logic [31:0] o_SRAM_DI;
    logic [31:0] i_SRAM_DO = '0;
    logic        o_empty;
    logic        o_full;

    dmem_write_buffer #(.DEPTH(4), .ADDR_W(14)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_DM_CS    (i_DM_CS),
        .i_DM_WEB   (i_DM_WEB),
        .i_DM_OE    (i_DM_OE),
        .i_DM_addr  (i_DM_addr),
        .i_DM_DI    (i_DM_DI),
        .o_DM_DO    (o_DM_DO),
        .o_SRAM_CS  (o_SRAM_CS),
        .o_SRAM_WEB (o_SRAM_WEB),
        .o_SRAM_A   (o_SRAM_A),
        .o_SRAM_DI  (o_SRAM_DI),
        .i_SRAM_DO  (i_SRAM_DO),
        .o_empty    (o_empty),
        .o_full     (o_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] a;
        logic [3:0]  web;
        logic [31:0] d;
    } wr_exp_t;

    wr_exp_t     wq[$];
    logic [31:0] rq[$];
    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    logic        rd_now = 1'b0;
    logic        rd_prev = 1'b0;

    logic [31:0] mem [0:1023];
    bit          mem_ready = 1'b0;

    function automatic logic [31:0] lane_mask(input logic [3:0] web);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++)
            m[b*8 +: 8] = {8{~web[b]}};
        return m;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Behavioural synchronous SRAM; word 0x20 preloaded with 0x12345678.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++)
                mem[i] = '0;
            mem[32'h20] = 32'h12345678;
            mem_ready = 1'b1;
        end
        if (o_SRAM_CS && o_SRAM_WEB == 4'hF) begin
            i_SRAM_DO <= mem[o_SRAM_A[9:0]];
        end else if (o_SRAM_CS) begin
            for (int b = 0; b < 4; b++)
                if (!o_SRAM_WEB[b])
                    mem[o_SRAM_A[9:0]][b*8 +: 8] = o_SRAM_DI[b*8 +: 8];
        end
        rd_prev <= rd_now;
    end

    always @(negedge clk) begin
        wr_exp_t e;
        logic [31:0] r;
        if (rst && o_SRAM_CS && o_SRAM_WEB != 4'hF) begin
            if (wq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_sram_write: got A=%h WEB=%h DI=%h expected none",
                         o_SRAM_A, o_SRAM_WEB, o_SRAM_DI);
            end else begin
                e = wq.pop_front();
                check("sram_write",
                      {14'b0, o_SRAM_A, o_SRAM_WEB, o_SRAM_DI & lane_mask(o_SRAM_WEB)},
                      {14'b0, e.a, e.web, e.d & lane_mask(e.web)});
            end
        end
        if (rd_prev) begin
            if (rq.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL read_data: got %h expected none queued", o_DM_DO);
            end else begin
                r = rq.pop_front();
                check("read_data", {32'b0, o_DM_DO}, {32'b0, r});
            end
        end
    end

    task automatic exp_wr(input logic [13:0] a, input logic [3:0] web, input logic [31:0] d);
        wr_exp_t e;
        e.a = a;
        e.web = web;
        e.d = d;
        wq.push_back(e);
    endtask

    task automatic cyc_write(input logic [31:0] addr, input logic [3:0] web, input logic [31:0] d);
        i_DM_CS = 1'b1; i_DM_OE = 1'b0; i_DM_WEB = web; i_DM_addr = addr; i_DM_DI = d;
        rd_now = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic cyc_read(input logic [31:0] addr, input logic [31:0] exp);
        i_DM_CS = 1'b1; i_DM_OE = 1'b1; i_DM_WEB = 4'hF; i_DM_addr = addr; i_DM_DI = '0;
        rd_now = 1'b1;
        rq.push_back(exp);
        @(posedge clk); #1;
    endtask

    task automatic cyc_idle();
        i_DM_CS = 1'b0; i_DM_OE = 1'b0; i_DM_WEB = 4'hF; i_DM_addr = '0; i_DM_DI = '0;
        rd_now = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_empty", o_empty, 1);
        check("reset_full", o_full, 0);
        check("reset_do", o_DM_DO, 0);
        check("reset_sram_cs", o_SRAM_CS, 0);
        rst = 1'b1;
        cyc_idle();

        // Full-word write drains on the following idle cycle.
        exp_wr(14'h010, 4'h0, 32'h11223344);
        cyc_write(32'h40, 4'h0, 32'h11223344);
        check("t1_not_empty", o_empty, 0);
        cyc_idle();
        check("t1_empty", o_empty, 1);

        // Single byte forwarded over SRAM data, then read back after drain.
        cyc_write(32'h80, 4'hE, 32'h000000AA);
        cyc_read(32'h80, 32'h123456AA);
        exp_wr(14'h020, 4'hE, 32'h000000AA);
        cyc_idle();
        check("t2_hold", o_DM_DO, 32'h123456AA);
        cyc_read(32'h80, 32'h123456AA);
        cyc_idle();

        // Fill to DEPTH; fifth write drains head and stays full.
        for (int k = 0; k < 4; k++) begin
            cyc_write(32'h100 + 32'(4*k), 4'h0, 32'hA0A00000 + 32'(k));
            if (k == 2) check("t3_not_full_at3", o_full, 0);
        end
        check("t3_full", o_full, 1);
        for (int k = 0; k < 5; k++)
            exp_wr(14'h040 + 14'(k), 4'h0, 32'hA0A00000 + 32'(k));
        cyc_write(32'h110, 4'h0, 32'hA0A00004);
        check("t3_full_hold", o_full, 1);
        repeat (4) cyc_idle();
        check("t3_empty", o_empty, 1);
        cyc_read(32'h110, 32'hA0A00004);
        cyc_read(32'h100, 32'hA0A00000);
        cyc_idle();

        // Two partial writes to one word coalesce into a single full-mask entry.
        cyc_write(32'h200, 4'hC, 32'h0000BEEF);
        cyc_write(32'h200, 4'h3, 32'hCAFE0000);
        cyc_read(32'h200, 32'hCAFEBEEF);
        exp_wr(14'h080, 4'h0, 32'hCAFEBEEF);
        cyc_idle();
        check("t4_empty", o_empty, 1);
        cyc_idle();

        // Reads stall draining; idle resumes; write to a draining head is pushed.
        for (int k = 0; k < 4; k++)
            cyc_write(32'h300 + 32'(4*k), 4'h0, 32'hB0B00000 + 32'(k));
        repeat (3) cyc_read(32'h300, 32'hB0B00000);
        check("t5_full_after_reads", o_full, 1);
        for (int k = 0; k < 5; k++)
            exp_wr(14'h0C0 + 14'(k), 4'h0, 32'hB0B00000 + 32'(k));
        exp_wr(14'h0C1, 4'h0, 32'h55555555);
        cyc_idle();
        check("t5_not_full", o_full, 0);
        cyc_write(32'h310, 4'h0, 32'hB0B00004);
        check("t5_refull", o_full, 1);
        cyc_write(32'h304, 4'h0, 32'h55555555);
        check("t5_head_push_full", o_full, 1);
        repeat (5) cyc_idle();
        check("t5_empty", o_empty, 1);
        cyc_read(32'h304, 32'h55555555);
        cyc_idle();

        // Reset with three entries buffered discards them.
        cyc_write(32'h400, 4'h0, 32'hDEAD0000);
        cyc_write(32'h404, 4'h0, 32'hDEAD0001);
        cyc_write(32'h408, 4'h0, 32'hDEAD0002);
        check("t6_not_empty", o_empty, 0);
        i_DM_CS = 1'b0; i_DM_OE = 1'b0; i_DM_WEB = 4'hF; i_DM_addr = '0; i_DM_DI = '0;
        rst = 1'b0;
        #1;
        check("t6_rst_empty", o_empty, 1);
        check("t6_rst_full", o_full, 0);
        check("t6_rst_do", o_DM_DO, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (3) cyc_idle();
        cyc_read(32'h400, 32'h00000000);
        repeat (2) cyc_idle();

        check("wq_drained", 64'(wq.size()), 0);
        check("rq_drained", 64'(rq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
